// File: rtl/pixel_scheduler.sv
//------------------------------------------------------------------------------
// pixel_scheduler
//
// Walks a WIDTH x HEIGHT pixel raster. For each pixel it hands the pixel
// coordinate and its complex-plane value c = re_c + j*im_c to an external
// depth calculator. It then waits for that calculator's result and streams
// the result out over a valid/ready interface. Coordinates are 32-bit signed
// fixed point with FRAC fractional bits, and all arithmetic on them wraps.
//
// Optional feature (macro PIXEL_SCHED_TIMEOUT_EN):
//   When the macro is defined, a WAIT-cycle counter forces a result of 8'hFF
//   after 4096 cycles without calc_done. It also sets the sticky timeout_err
//   output. When the macro is undefined, that port and the counter do not
//   exist and WAIT lasts until calc_done.
//
// Ports
//   sysclk, reset_n           clock (rising edge), synchronous active-low reset
//   frame_start               request to scan one frame (ignored while busy)
//   re_origin, im_origin      c of pixel (0,0), latched at frame start
//   step                      per-pixel c increment, latched at frame start
//   calc_start                one-cycle start pulse to the depth calculator
//   calc_x/y, calc_re_c/im_c  current pixel and its c value; stable from
//                             ISSUE until the result handshake
//   calc_done, calc_depth     calculator completion level and result
//   pix_valid/ready           result stream handshake
//   pix_x/y, pix_depth        result payload
//   pix_sof, pix_eol          first pixel of frame / last pixel of line
//   timeout_err               sticky calculator timeout flag (macro only)
//   busy                      frame in progress
//------------------------------------------------------------------------------
module pixel_scheduler #(
    parameter int FRAC   = 16,
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic        sysclk,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic [31:0] re_origin,
    input  logic [31:0] im_origin,
    input  logic [31:0] step,
    output logic        calc_start,
    output logic [9:0]  calc_x,
    output logic [8:0]  calc_y,
    output logic [31:0] calc_re_c,
    output logic [31:0] calc_im_c,
    input  logic        calc_done,
    input  logic [7:0]  calc_depth,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [7:0]  pix_depth,
    output logic        pix_sof,
    output logic        pix_eol,
`ifdef PIXEL_SCHED_TIMEOUT_EN
    output logic        timeout_err,
`endif
    output logic        busy
);

    // The raster and coordinate formats must fit the fixed port widths.
    if (FRAC < 0 || FRAC > 31 || WIDTH < 1 || WIDTH > 1024 ||
        HEIGHT < 1 || HEIGHT > 512) begin : g_param_check
        $error("pixel_scheduler: FRAC/WIDTH/HEIGHT out of range");
    end

    localparam logic [9:0] X_LAST = 10'(WIDTH - 1);
    localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUTPUT
    } state_t;

    state_t      state_q,      state_d;
    logic [9:0]  x_q,          x_d;
    logic [8:0]  y_q,          y_d;
    logic [31:0] re_c_q,       re_c_d;
    logic [31:0] im_c_q,       im_c_d;
    logic [31:0] re_org_q,     re_org_d;
    logic [31:0] im_org_q,     im_org_d;
    logic [31:0] step_q,       step_d;
    logic        busy_q,       busy_d;
    logic        calc_start_q, calc_start_d;
    logic        first_wait_q, first_wait_d;
    logic        pix_valid_q,  pix_valid_d;
    logic [9:0]  pix_x_q,      pix_x_d;
    logic [8:0]  pix_y_q,      pix_y_d;
    logic [7:0]  pix_depth_q,  pix_depth_d;
    logic        pix_sof_q,    pix_sof_d;
    logic        pix_eol_q,    pix_eol_d;
`ifdef PIXEL_SCHED_TIMEOUT_EN
    logic [11:0] wait_cnt_q,   wait_cnt_d;
    logic        timeout_err_q, timeout_err_d;
`endif

    // Result capture strobe and the depth value it stores.
    logic        capture;
    logic [7:0]  capture_depth;

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d defaults to its _q (or to an idle value) before the case
        // statement. No path then leaves a signal unassigned, which would infer a latch.
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        re_c_d        = re_c_q;
        im_c_d        = im_c_q;
        re_org_d      = re_org_q;
        im_org_d      = im_org_q;
        step_d        = step_q;
        busy_d        = busy_q;
        calc_start_d  = 1'b0;
        first_wait_d  = 1'b0;
        pix_valid_d   = pix_valid_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        pix_depth_d   = pix_depth_q;
        pix_sof_d     = pix_sof_q;
        pix_eol_d     = pix_eol_q;
        capture       = 1'b0;
        capture_depth = calc_depth;
`ifdef PIXEL_SCHED_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    re_org_d     = re_origin;
                    im_org_d     = im_origin;
                    step_d       = step;
                    x_d          = '0;
                    y_d          = '0;
                    re_c_d       = re_origin;
                    im_c_d       = im_origin;
                    busy_d       = 1'b1;
                    // calc_start is registered, so raise it on entry to ISSUE.
                    calc_start_d = 1'b1;
                    state_d      = ISSUE;
                end
            end

            ISSUE: begin
                first_wait_d = 1'b1;
`ifdef PIXEL_SCHED_TIMEOUT_EN
                wait_cnt_d   = '0;
`endif
                state_d      = WAIT;
            end

            WAIT: begin
                // calc_done in the first WAIT cycle may still be the previous
                // pixel's level, so it is only trusted from the second cycle.
                if (!first_wait_q && calc_done) begin
                    capture = 1'b1;
                end
`ifdef PIXEL_SCHED_TIMEOUT_EN
                // wait_cnt_q counts completed WAIT cycles. Reaching 4095 here
                // means this is the 4096th cycle without a result.
                else if (wait_cnt_q == 12'hFFF) begin
                    capture       = 1'b1;
                    capture_depth = 8'hFF;
                    timeout_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 12'd1;
                end
`endif
                if (capture) begin
                    pix_depth_d = capture_depth;
                    pix_x_d     = x_q;
                    pix_y_d     = y_q;
                    pix_sof_d   = (x_q == '0) && (y_q == '0);
                    pix_eol_d   = (x_q == X_LAST);
                    pix_valid_d = 1'b1;
                    state_d     = OUTPUT;
                end
            end

            OUTPUT: begin
                if (pix_ready) begin
                    pix_valid_d = 1'b0;
                    pix_sof_d   = 1'b0;
                    pix_eol_d   = 1'b0;
                    if (x_q != X_LAST) begin
                        x_d          = x_q + 10'd1;
                        re_c_d       = re_c_q + step_q;
                        calc_start_d = 1'b1;
                        state_d      = ISSUE;
                    end else if (y_q != Y_LAST) begin
                        // Imaginary axis decreases down the frame.
                        x_d          = '0;
                        y_d          = y_q + 9'd1;
                        re_c_d       = re_org_q;
                        im_c_d       = im_c_q - step_q;
                        calc_start_d = 1'b1;
                        state_d      = ISSUE;
                    end else begin
                        // This is the last pixel. A frame_start in this same
                        // cycle is dropped, because only IDLE looks at it.
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // State registers
    //--------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples its _d value from before the edge, whatever order the
    // statements appear in.
    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            // Reset also drops any calculator result still in flight. Nothing
            // is restarted until a fresh frame_start arrives in IDLE.
            state_q       <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            re_c_q        <= '0;
            im_c_q        <= '0;
            re_org_q      <= '0;
            im_org_q      <= '0;
            step_q        <= '0;
            busy_q        <= 1'b0;
            calc_start_q  <= 1'b0;
            first_wait_q  <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_depth_q   <= '0;
            pix_sof_q     <= 1'b0;
            pix_eol_q     <= 1'b0;
`ifdef PIXEL_SCHED_TIMEOUT_EN
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            re_c_q        <= re_c_d;
            im_c_q        <= im_c_d;
            re_org_q      <= re_org_d;
            im_org_q      <= im_org_d;
            step_q        <= step_d;
            busy_q        <= busy_d;
            calc_start_q  <= calc_start_d;
            first_wait_q  <= first_wait_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_depth_q   <= pix_depth_d;
            pix_sof_q     <= pix_sof_d;
            pix_eol_q     <= pix_eol_d;
`ifdef PIXEL_SCHED_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    //--------------------------------------------------------------------------
    // Outputs (all registered)
    //--------------------------------------------------------------------------
    assign calc_start  = calc_start_q;
    assign calc_x      = x_q;
    assign calc_y      = y_q;
    assign calc_re_c   = re_c_q;
    assign calc_im_c   = im_c_q;
    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_depth   = pix_depth_q;
    assign pix_sof     = pix_sof_q;
    assign pix_eol     = pix_eol_q;
    assign busy        = busy_q;
`ifdef PIXEL_SCHED_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`endif

endmodule
